// File: rtl/pht_sat_tab_if.sv
// Request/response bundle between the index hash, fetch stage and the pattern history table.
// Master drives requests; slave is the table.
interface pht_sat_tab_if #(
    parameter int unsigned IDX_W = 14,
    parameter int unsigned CNT_W = 2
);
    logic             flush;
    logic             pred_en;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_valid;
    logic [CNT_W-1:0] pred_cnt;
    logic             pred_taken;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             ready;

    modport master (
        output flush, pred_en, pred_idx, upd_en, upd_idx, upd_taken,
        input  pred_valid, pred_cnt, pred_taken, ready
    );

    modport slave (
        input  flush, pred_en, pred_idx, upd_en, upd_idx, upd_taken,
        output pred_valid, pred_cnt, pred_taken, ready
    );
endinterface

// File: rtl/pht_sat_tab.sv
// Pattern history table of 2^IDX_W saturating counters: one registered prediction read and
// one training update per cycle, with a self-initialising sweep after reset or flush.
module pht_sat_tab #(
    parameter int unsigned IDX_W    = 14,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned INIT_VAL = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    pht_sat_tab_if.slave   bus_io
);
    localparam int unsigned      Depth   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] InitVal = CNT_W'(INIT_VAL);
    localparam logic [IDX_W-1:0] LastIdx = '1;

    typedef enum logic {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             pred_valid_q, pred_valid_d;
    logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;

    logic [CNT_W-1:0] mem_q [Depth];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] wr_val;
    logic [CNT_W-1:0] upd_old;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pred_valid_d = 1'b0;
        pred_cnt_d   = pred_cnt_q;
        wr_en        = 1'b0;
        wr_idx       = ptr_q;
        wr_val       = InitVal;
        upd_old      = mem_q[bus_io.upd_idx];

        unique case (state_q)
            StInit: begin
                wr_en = 1'b1;
                if (bus_io.flush) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LastIdx) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // A flush drops any concurrent request so the sweep starts from a clean table.
                if (bus_io.flush) begin
                    state_d = StInit;
                    ptr_d   = '0;
                end else begin
                    pred_valid_d = bus_io.pred_en;
                    if (bus_io.pred_en) begin
                        pred_cnt_d = mem_q[bus_io.pred_idx];
                    end
                    if (bus_io.upd_en) begin
                        wr_en  = 1'b1;
                        wr_idx = bus_io.upd_idx;
                        if (bus_io.upd_taken) begin
                            wr_val = (upd_old == CntMax) ? upd_old : upd_old + 1'b1;
                        end else begin
                            wr_val = (upd_old == '0) ? upd_old : upd_old - 1'b1;
                        end
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInit;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pred_valid_q <= pred_valid_d;
            pred_cnt_q   <= pred_cnt_d;
        end
    end

    // Read above uses the pre-edge contents, giving read-before-write on a shared index.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_val;
        end
    end

    assign bus_io.ready      = (state_q == StRun);
    assign bus_io.pred_valid = pred_valid_q;
    assign bus_io.pred_cnt   = pred_cnt_q;
    assign bus_io.pred_taken = pred_cnt_q[CNT_W-1];
endmodule

// File: tb/tb_pht_sat_tab.sv
// Scoreboard bench for pht_sat_tab: a 2-bit table (dut_a) and a 3-bit table (dut_b).
// Directed stimulus pushes hand-computed counter values; monitors pop on pred_valid.
module tb_pht_sat_tab;
    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;

    always #5 clk = ~clk;

    pht_sat_tab_if #(.IDX_W(4), .CNT_W(2)) bus_a ();
    pht_sat_tab_if #(.IDX_W(4), .CNT_W(3)) bus_b ();

    pht_sat_tab #(.IDX_W(4), .CNT_W(2), .INIT_VAL(1)) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus_io  (bus_a.slave)
    );

    pht_sat_tab #(.IDX_W(4), .CNT_W(3), .INIT_VAL(1)) dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus_io  (bus_b.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_a[$];
    int exp_b[$];
    int ea;
    int eb;
    int n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: taken is the counter MSB, i.e. value >= half of the range.
    always @(negedge clk) begin
        if (bus_a.pred_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                ea = exp_a.pop_front();
                check("a_pred_cnt", 32'(bus_a.pred_cnt), ea);
                check("a_pred_taken", 32'(bus_a.pred_taken), 32'(ea >= 2));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.pred_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                eb = exp_b.pop_front();
                check("b_pred_cnt", 32'(bus_b.pred_cnt), eb);
                check("b_pred_taken", 32'(bus_b.pred_taken), 32'(eb >= 4));
            end
        end
    end

    task automatic a_cyc(input bit pe, input int pi, input bit ue, input int ui, input bit ut,
                         input bit fl);
        bus_a.pred_en   = pe;
        bus_a.pred_idx  = pi[3:0];
        bus_a.upd_en    = ue;
        bus_a.upd_idx   = ui[3:0];
        bus_a.upd_taken = ut;
        bus_a.flush     = fl;
        @(negedge clk);
    endtask

    task automatic b_cyc(input bit pe, input int pi, input bit ue, input int ui, input bit ut,
                         input bit fl);
        bus_b.pred_en   = pe;
        bus_b.pred_idx  = pi[3:0];
        bus_b.upd_en    = ue;
        bus_b.upd_idx   = ui[3:0];
        bus_b.upd_taken = ut;
        bus_b.flush     = fl;
        @(negedge clk);
    endtask

    task automatic a_pred(input int idx, input int exp);
        exp_a.push_back(exp);
        a_cyc(1'b1, idx, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic b_pred(input int idx, input int exp);
        exp_b.push_back(exp);
        b_cyc(1'b1, idx, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input bit sel, output int cnt);
        cnt = 0;
        while ((sel ? bus_b.ready : bus_a.ready) !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.pred_en = 1'b0; bus_a.pred_idx = '0; bus_a.upd_en = 1'b0;
        bus_a.upd_idx = '0; bus_a.upd_taken = 1'b0; bus_a.flush = 1'b0;
        bus_b.pred_en = 1'b0; bus_b.pred_idx = '0; bus_b.upd_en = 1'b0;
        bus_b.upd_idx = '0; bus_b.upd_taken = 1'b0; bus_b.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("a_rst_ready", 32'(bus_a.ready), 32'd0);
        check("a_rst_valid", 32'(bus_a.pred_valid), 32'd0);
        check("a_rst_cnt", 32'(bus_a.pred_cnt), 32'd0);
        check("a_rst_taken", 32'(bus_a.pred_taken), 32'd0);

        // 1: init sweep, then every entry reads INIT_VAL
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        wait_ready(1'b0, n);
        check("a_init_cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) a_pred(i, 1);
        a_cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        // 2: taken updates saturate at 3
        a_cyc(1'b0, 0, 1'b1, 5, 1'b1, 1'b0); a_pred(5, 2);
        a_cyc(1'b0, 0, 1'b1, 5, 1'b1, 1'b0); a_pred(5, 3);
        a_cyc(1'b0, 0, 1'b1, 5, 1'b1, 1'b0); a_pred(5, 3);

        // 3: not-taken updates saturate at 0
        a_cyc(1'b0, 0, 1'b1, 5, 1'b0, 1'b0); a_pred(5, 2);
        a_cyc(1'b0, 0, 1'b1, 5, 1'b0, 1'b0); a_pred(5, 1);
        a_cyc(1'b0, 0, 1'b1, 5, 1'b0, 1'b0); a_pred(5, 0);
        a_cyc(1'b0, 0, 1'b1, 5, 1'b0, 1'b0); a_pred(5, 0);

        // 4: same-index read-before-write
        exp_a.push_back(1);
        a_cyc(1'b1, 7, 1'b1, 7, 1'b1, 1'b0);
        a_pred(7, 2);

        // 5: flush drops concurrent requests; pred_en held during the sweep
        a_cyc(1'b1, 3, 1'b1, 3, 1'b1, 1'b1);
        bus_a.flush   = 1'b0;
        bus_a.upd_en  = 1'b0;
        bus_a.pred_en = 1'b1;
        wait_ready(1'b0, n);
        bus_a.pred_en = 1'b0;
        check("a_flush_init_cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) a_pred(i, 1);
        a_cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        // 6: reset mid-sweep on the 3-bit table
        b_pred(0, 1);
        b_cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        bus_b.flush = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_b_n = 1'b0;
        #1;
        check("b_rst_ready", 32'(bus_b.ready), 32'd0);
        check("b_rst_valid", 32'(bus_b.pred_valid), 32'd0);
        check("b_rst_cnt", 32'(bus_b.pred_cnt), 32'd0);
        check("b_rst_taken", 32'(bus_b.pred_taken), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        wait_ready(1'b1, n);
        check("b_init_cycles", n, 32'd16);
        for (int k = 1; k <= 7; k++) begin
            b_cyc(1'b0, 0, 1'b1, 2, 1'b1, 1'b0);
            b_pred(2, (k + 1 > 7) ? 7 : k + 1);
        end
        b_pred(6, 1);
        b_cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("a_queue_drained", exp_a.size(), 32'd0);
        check("b_queue_drained", exp_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pht_sat_tab.md
# pht_sat_tab

Parametrised pattern history table for the branch predictor. It holds 2^IDX_W saturating counters and serves one prediction read and one training update per cycle. It self-initialises every entry after reset or flush, and supports a configurable counter width. It sits between the index hash (prediction and resolution paths) and the fetch-stage taken/not-taken decision.

## Interface

Parameters:
- IDX_W, 14, index width; table depth = 2^IDX_W entries
- CNT_W, 2, counter width in bits (legal range 1..4)
- INIT_VAL, 1, value written to every entry during init (must be < 2^CNT_W); default is weakly not-taken

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous request to re-initialise the whole table
- pred_en  in  1  prediction read request
- pred_idx  in  IDX_W  prediction index
- pred_valid  out  1  registered; pred_cnt/pred_taken are valid this cycle
- pred_cnt  out  CNT_W  registered counter value read
- pred_taken  out  1  registered; equals MSB of pred_cnt
- upd_en  in  1  training update request
- upd_idx  in  IDX_W  update index
- upd_taken  in  1  resolved direction: 1 = taken, 0 = not taken
- ready  out  1  high when the table is in RUN and accepts requests

## Operation

- FSM states: INIT and RUN.
- Reset (reset_n=0, asynchronous):
  - state=INIT, init pointer=0.
  - ready, pred_valid, pred_cnt and pred_taken all 0.
  - Table contents are undefined until the sweep completes.
- INIT:
  - Each cycle, write INIT_VAL to entry[pointer] and increment the pointer.
  - After writing entry 2^IDX_W-1, go to RUN. ready=1 from the following cycle.
  - pred_en and upd_en are ignored. pred_valid stays 0.
- RUN, prediction:
  - If pred_en=1, the next cycle gives pred_valid=1, pred_cnt=entry[pred_idx] and pred_taken=pred_cnt[CNT_W-1].
  - If pred_en=0, the next cycle gives pred_valid=0; pred_cnt and pred_taken hold their last values.
- RUN, update:
  - If upd_en=1, entry[upd_idx] is rewritten on the same edge.
  - upd_taken=1: new value = min(old+1, 2^CNT_W-1).
  - upd_taken=0: new value = max(old-1, 0).
  - Saturating arithmetic; the counter never wraps.
- Simultaneous pred_en and upd_en on the same index: read-before-write. The prediction returns the pre-update value, and the update still commits.
- Simultaneous on different indices: both complete independently.
- flush=1 in RUN:
  - Next cycle: state=INIT, pointer=0, ready=0, pred_valid=0.
  - Any pred_en or upd_en in the flush cycle is dropped and does not modify the table.
- flush=1 in INIT: the pointer restarts at 0.
- reset_n asserted at any time (including mid-INIT): immediate return to the reset state; the sweep restarts from 0 after release.

## Timing

- Prediction latency: 1 cycle (request on edge N, data valid after edge N+1).
- Update latency: 0 cycles; the entry holds the new value after edge N. A prediction on edge N+1 sees it.
- Throughput: 1 prediction + 1 update per cycle, with no stalls in RUN.
- INIT duration: exactly 2^IDX_W cycles from the first rising edge after reset_n deassertion (or after the flush edge); ready rises at the next edge.
- ready, pred_valid, pred_cnt and pred_taken are registered outputs with no combinational path from inputs.

## Test plan

All scenarios use IDX_W=4, CNT_W=2, INIT_VAL=1.

1. Release reset_n -> ready=0 for exactly 16 cycles, then 1. Predict idx 0..15 -> every pred_cnt=1 and pred_taken=0, each one cycle after its request.
2. Three taken updates to idx 5 -> predicts after each give 2, 3, 3. pred_taken=1 from the first update onward.
3. From 3, four not-taken updates to idx 5 -> predicts give 2, 1, 0, 0. pred_taken is 0 once the value drops below 2.
4. Same cycle: pred_en + upd_en (taken) both on idx 7 at value 1 -> pred_cnt=1. A predict on the next cycle returns 2.
5. flush in RUN with a concurrent upd_en on idx 3 -> ready=0 next cycle for 16 cycles. Afterwards every entry reads 1, including idx 3. pred_valid stays 0 during INIT despite pred_en.
6. Assert reset_n=0 when the init pointer is 9 -> all outputs 0 immediately. After release, the full 16-cycle sweep runs from 0. With CNT_W=3, taken updates then saturate at 7.
